// File: rtl/servile_arb_pkg.sv
// Shared types and helpers for the Servile Wishbone memory-port arbiter.
//   arb_state_e : arbiter FSM states (ST_IDLE, ST_BUSY)
//   PRIO_RR / PRIO_FIXED : priority-mode encodings handed to the picker
//   clog2_min1  : index width for a master count, never less than 1 bit
package servile_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam logic PRIO_RR    = 1'b0;
  localparam logic PRIO_FIXED = 1'b1;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/servile_arb_picker.sv
// Combinational priority picker.
//   i_req   : request vector, one bit per master
//   i_start : first index searched in round-robin mode (wraps mod N)
//   i_mode  : PRIO_RR or PRIO_FIXED (fixed always searches from index 0)
//   o_valid : at least one request is set
//   o_idx   : winning master index
module servile_arb_picker
  import servile_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int GW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [GW-1:0] i_start,
  input  logic          i_mode,
  output logic          o_valid,
  output logic [GW-1:0] o_idx
);

  always_comb begin
    int            cand;
    logic [GW-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    o_valid  = 1'b0;
    o_idx    = '0;
    for (int i = 0; i < N; i++) begin
      cand     = (i_mode == PRIO_FIXED) ? i : (int'(i_start) + i) % N;
      cand_idx = GW'(cand);
      if (!o_valid && i_req[cand_idx]) begin
        o_valid = 1'b1;
        o_idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/servile_wb_arbiter.sv
// N-master to 1-slave classic Wishbone arbiter for the Servile memory port.
// Grant is registered: a request seen in IDLE is granted and forwarded to the
// slave on the following cycle; slave ack is returned to the granted master in
// the same cycle, after which the arbiter spends one cycle in IDLE.
//
// Ports:
//   i_clk, i_rst_n            : clock, asynchronous active-low reset
//   i_wb_cpu_*                : N packed master request buses (master k at slice k)
//   o_wb_cpu_rdt/o_wb_cpu_ack : shared read data, one-hot per-master ack
//   o_wb_mem_*, i_wb_mem_*    : single slave port
//   o_grant                   : current / most recent granted master
//   o_timeout                 : sticky watchdog flag
//
// Build option: define SERVILE_ARB_TIMEOUT_EN to add a BUSY watchdog that
// completes a stalled transfer with TIMEOUT_RDT after TIMEOUT_CYCLES cycles.
// Without it o_timeout stays 0 and BUSY waits indefinitely.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no transfer; picker selects the next master from the strobes
// ST_BUSY | slave strobed on behalf of grant_q until ack, abort or timeout
module servile_wb_arbiter
  import servile_arb_pkg::*;
#(
  parameter int          N              = 2,
  parameter int          AW             = 32,
  parameter int          DW             = 32,
  parameter string       PRIO_MODE      = "RR",
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_RDT    = 32'hDEAD_BEEF,
  localparam int         SW             = DW / 8,
  localparam int         GW             = clog2_min1(N)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N*AW-1:0] i_wb_cpu_adr,
  input  logic [N*DW-1:0] i_wb_cpu_dat,
  input  logic [N*SW-1:0] i_wb_cpu_sel,
  input  logic [N-1:0]    i_wb_cpu_we,
  input  logic [N-1:0]    i_wb_cpu_stb,
  output logic [DW-1:0]   o_wb_cpu_rdt,
  output logic [N-1:0]    o_wb_cpu_ack,
  output logic [AW-1:0]   o_wb_mem_adr,
  output logic [DW-1:0]   o_wb_mem_dat,
  output logic [SW-1:0]   o_wb_mem_sel,
  output logic            o_wb_mem_we,
  output logic            o_wb_mem_stb,
  input  logic [DW-1:0]   i_wb_mem_rdt,
  input  logic            i_wb_mem_ack,
  output logic [GW-1:0]   o_grant,
  output logic            o_timeout
);

  localparam logic            MODE     = (PRIO_MODE == "FIXED") ? PRIO_FIXED : PRIO_RR;
  localparam logic [GW-1:0]   LAST_RST = GW'(N - 1);
  localparam int              WDW      = clog2_min1(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0]  WD_LOAD  = WDW'(TIMEOUT_CYCLES);

  arb_state_e    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_grant_q, last_grant_d;
  logic          timeout_q, timeout_d;

  logic [GW-1:0] start_idx;
  logic          pick_valid;
  logic [GW-1:0] pick_idx;
  logic          gnt_stb;
  logic          wd_expired;
  logic          tmo_fire;

  // Reset value N-1 for last_grant makes master 0 the first RR candidate.
  assign start_idx = (last_grant_q == LAST_RST) ? '0 : last_grant_q + GW'(1);

  servile_arb_picker #(
    .N  (N),
    .GW (GW)
  ) u_picker (
    .i_req   (i_wb_cpu_stb),
    .i_start (start_idx),
    .i_mode  (MODE),
    .o_valid (pick_valid),
    .o_idx   (pick_idx)
  );

  always_comb begin
    o_wb_mem_adr = '0;
    o_wb_mem_dat = '0;
    o_wb_mem_sel = '0;
    o_wb_mem_we  = 1'b0;
    gnt_stb      = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (grant_q == GW'(k)) begin
        o_wb_mem_adr = i_wb_cpu_adr[k*AW +: AW];
        o_wb_mem_dat = i_wb_cpu_dat[k*DW +: DW];
        o_wb_mem_sel = i_wb_cpu_sel[k*SW +: SW];
        o_wb_mem_we  = i_wb_cpu_we[k];
        gnt_stb      = i_wb_cpu_stb[k];
      end
    end
  end

`ifdef SERVILE_ARB_TIMEOUT_EN
  logic [WDW-1:0] wd_q, wd_d;

  // Reloaded every IDLE cycle so it starts full on entry to BUSY.
  always_comb begin
    wd_d = wd_q;
    if (state_q == ST_IDLE) begin
      wd_d = WD_LOAD;
    end else if (wd_q != '0) begin
      wd_d = wd_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wd_q <= WD_LOAD;
    end else begin
      wd_q <= wd_d;
    end
  end

  assign wd_expired = (state_q == ST_BUSY) && (wd_q == '0);
`else
  logic unused_wd;
  assign unused_wd  = ^WD_LOAD;
  assign wd_expired = 1'b0;
`endif

  // A real ack in the expiry cycle is a normal completion; a master that has
  // already dropped stb is an abort, not a timeout.
  assign tmo_fire = wd_expired && gnt_stb && !i_wb_mem_ack;

  // Deliberately independent of i_wb_mem_ack so a slave may ack combinationally.
  assign o_wb_mem_stb = (state_q == ST_BUSY) && gnt_stb && !wd_expired;
  assign o_wb_cpu_rdt = tmo_fire ? DW'(TIMEOUT_RDT) : i_wb_mem_rdt;
  assign o_grant      = grant_q;
  assign o_timeout    = timeout_q;

  always_comb begin
    o_wb_cpu_ack = '0;
    if ((state_q == ST_BUSY) && (i_wb_mem_ack || tmo_fire)) begin
      o_wb_cpu_ack[grant_q] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    timeout_d    = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (i_wb_mem_ack || tmo_fire) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
          if (tmo_fire) begin
            timeout_d = 1'b1;
          end
        end else if (!gnt_stb) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_RST;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      timeout_q    <= timeout_d;
    end
  end

endmodule

// File: tb/tb_servile_wb_arbiter.sv
module tb_servile_wb_arbiter;

  localparam logic [31:0] K = 32'hA5A5_0000;

  typedef struct {
    int          m;
    logic [31:0] rdt;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT A: 3 masters, round-robin, short watchdog
  logic [95:0] a_adr, a_dat;
  logic [11:0] a_sel;
  logic [2:0]  a_we, a_stb, a_ack;
  logic [31:0] a_rdt, a_madr, a_mdat, a_mrdt;
  logic [3:0]  a_msel;
  logic        a_mwe, a_mstb, a_mack, a_tmo;
  logic [1:0]  a_grant;

  // DUT B: 2 masters, fixed priority
  logic [63:0] b_adr, b_dat;
  logic [7:0]  b_sel;
  logic [1:0]  b_we, b_stb, b_ack;
  logic [31:0] b_rdt, b_madr, b_mdat, b_mrdt;
  logic [3:0]  b_msel;
  logic        b_mwe, b_mstb, b_mack, b_tmo;
  logic [0:0]  b_grant;

  servile_wb_arbiter #(
    .N(3), .AW(32), .DW(32), .PRIO_MODE("RR"), .TIMEOUT_CYCLES(8), .TIMEOUT_RDT(32'hDEAD_BEEF)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wb_cpu_adr(a_adr), .i_wb_cpu_dat(a_dat), .i_wb_cpu_sel(a_sel),
    .i_wb_cpu_we(a_we), .i_wb_cpu_stb(a_stb),
    .o_wb_cpu_rdt(a_rdt), .o_wb_cpu_ack(a_ack),
    .o_wb_mem_adr(a_madr), .o_wb_mem_dat(a_mdat), .o_wb_mem_sel(a_msel),
    .o_wb_mem_we(a_mwe), .o_wb_mem_stb(a_mstb),
    .i_wb_mem_rdt(a_mrdt), .i_wb_mem_ack(a_mack),
    .o_grant(a_grant), .o_timeout(a_tmo)
  );

  servile_wb_arbiter #(
    .N(2), .AW(32), .DW(32), .PRIO_MODE("FIXED"), .TIMEOUT_CYCLES(255), .TIMEOUT_RDT(32'hDEAD_BEEF)
  ) dut_fx (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wb_cpu_adr(b_adr), .i_wb_cpu_dat(b_dat), .i_wb_cpu_sel(b_sel),
    .i_wb_cpu_we(b_we), .i_wb_cpu_stb(b_stb),
    .o_wb_cpu_rdt(b_rdt), .o_wb_cpu_ack(b_ack),
    .o_wb_mem_adr(b_madr), .o_wb_mem_dat(b_mdat), .o_wb_mem_sel(b_msel),
    .o_wb_mem_we(b_mwe), .o_wb_mem_stb(b_mstb),
    .i_wb_mem_rdt(b_mrdt), .i_wb_mem_ack(b_mack),
    .o_grant(b_grant), .o_timeout(b_tmo)
  );

  task automatic do_reset();
    rst_n  = 1'b0;
    a_adr  = '0; a_dat = '0; a_sel = '0; a_we = '0; a_stb = '0;
    a_mrdt = '0; a_mack = 1'b0;
    b_adr  = '0; b_dat = '0; b_sel = '0; b_we = '0; b_stb = '0;
    b_mrdt = '0; b_mack = 1'b0;
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_tests++; if (a_mstb !== 1'b0) begin n_fail++; $display("FAIL reset_mem_stb got %b want 0", a_mstb); end
    n_tests++; if (a_ack !== 3'b000) begin n_fail++; $display("FAIL reset_ack got %b want 000", a_ack); end
    n_tests++; if (a_grant !== 2'd0) begin n_fail++; $display("FAIL reset_grant got %0d want 0", a_grant); end
    n_tests++; if (a_tmo !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b want 0", a_tmo); end
    n_tests++; if (b_grant !== 1'b0 || b_mstb !== 1'b0) begin
      n_fail++; $display("FAIL reset_fixed got grant=%0d stb=%b want 0/0", b_grant, b_mstb);
    end
  endtask

  task automatic test_single();
    exp_t e;
    do_reset();
    @(negedge clk);
    a_adr[31:0] = 32'h100; a_sel[3:0] = 4'hF; a_we[0] = 1'b0; a_stb[0] = 1'b1;
    sb_q.push_back('{m: 0, rdt: 32'h100 ^ K, dat: 32'h0, sel: 4'hF, we: 1'b0});
    #1;
    n_tests++; if (a_mstb !== 1'b0) begin n_fail++; $display("FAIL single_req_cycle_stb got %b want 0", a_mstb); end
    @(negedge clk); #1;
    n_tests++; if (a_mstb !== 1'b1 || a_madr !== 32'h100) begin
      n_fail++; $display("FAIL single_issue got stb=%b adr=%h want 1/00000100", a_mstb, a_madr);
    end
    n_tests++; if (a_ack !== 3'b000) begin n_fail++; $display("FAIL single_early_ack got %b want 000", a_ack); end
    @(negedge clk);
    a_mack = 1'b1; a_mrdt = a_madr ^ K;
    #1;
    e = sb_q.pop_front();
    n_tests++; if (a_ack !== 3'(1 << e.m)) begin n_fail++; $display("FAIL single_ack got %b want %b", a_ack, 3'(1 << e.m)); end
    n_tests++; if (a_rdt !== e.rdt) begin n_fail++; $display("FAIL single_rdt got %h want %h", a_rdt, e.rdt); end
    @(negedge clk);
    a_mack = 1'b0;
    #1;
    n_tests++; if (a_mstb !== 1'b0 || a_ack !== 3'b000) begin
      n_fail++; $display("FAIL single_no_reissue got stb=%b ack=%b want 0/000", a_mstb, a_ack);
    end
    n_tests++; if (a_tmo !== 1'b0) begin n_fail++; $display("FAIL single_timeout_flag got %b want 0", a_tmo); end
    a_stb[0] = 1'b0;
  endtask

  task automatic test_rr();
    exp_t e;
    int acks = 0, cyc = 0, last_cyc = 0;
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      a_adr[k*32 +: 32] = 32'h1000 + 32'(k * 16);
      a_dat[k*32 +: 32] = 32'hC0DE_0000 + 32'(k);
      a_sel[k*4 +: 4]   = 4'(1 << k);
      a_we[k]           = k[0];
    end
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 3; k++)
        sb_q.push_back('{m: k, rdt: (32'h1000 + 32'(k * 16)) ^ K, dat: 32'hC0DE_0000 + 32'(k),
                         sel: 4'(1 << k), we: k[0]});
    a_stb = 3'b111;
    while (acks < 6 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      a_mack = a_mstb; a_mrdt = a_madr ^ K;
      #1;
      if (a_ack !== 3'b000) begin
        if (sb_q.size() == 0) begin
          n_tests++; n_fail++; $display("FAIL rr_extra_ack got %b want none", a_ack);
        end else begin
          e = sb_q.pop_front();
          n_tests++; if (a_ack !== 3'(1 << e.m) || a_grant !== 2'(e.m)) begin
            n_fail++; $display("FAIL rr_order got ack=%b grant=%0d want master %0d", a_ack, a_grant, e.m);
          end
          n_tests++; if (a_rdt !== e.rdt || a_mdat !== e.dat || a_msel !== e.sel || a_mwe !== e.we) begin
            n_fail++; $display("FAIL rr_mux got rdt=%h dat=%h sel=%h we=%b want %h %h %h %b",
                               a_rdt, a_mdat, a_msel, a_mwe, e.rdt, e.dat, e.sel, e.we);
          end
        end
        if (acks > 0) begin
          n_tests++; if (cyc - last_cyc != 2) begin
            n_fail++; $display("FAIL rr_spacing got %0d cycles want 2", cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        acks++;
      end
    end
    n_tests++; if (acks != 6) begin n_fail++; $display("FAIL rr_count got %0d acks want 6", acks); end
    @(negedge clk);
    a_stb = '0; a_mack = 1'b0;
  endtask

  task automatic test_fixed();
    exp_t e;
    int acks = 0, cyc = 0;
    do_reset();
    @(negedge clk);
    b_adr = {32'h300, 32'h200}; b_sel = '1;
    for (int i = 0; i < 3; i++) sb_q.push_back('{m: 0, rdt: 32'h200 ^ K, dat: 32'h0, sel: 4'hF, we: 1'b0});
    sb_q.push_back('{m: 1, rdt: 32'h300 ^ K, dat: 32'h0, sel: 4'hF, we: 1'b0});
    b_stb = 2'b11;
    while (acks < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      b_mack = b_mstb; b_mrdt = b_madr ^ K;
      #1;
      if (b_ack !== 2'b00) begin
        if (sb_q.size() == 0) begin
          n_tests++; n_fail++; $display("FAIL fixed_extra_ack got %b want none", b_ack);
        end else begin
          e = sb_q.pop_front();
          n_tests++; if (b_ack !== 2'(1 << e.m)) begin
            n_fail++; $display("FAIL fixed_winner got %b want %b", b_ack, 2'(1 << e.m));
          end
          n_tests++; if (b_rdt !== e.rdt) begin n_fail++; $display("FAIL fixed_rdt got %h want %h", b_rdt, e.rdt); end
        end
        acks++;
        if (acks == 3) b_stb[0] = 1'b0;
      end
    end
    n_tests++; if (acks != 4) begin n_fail++; $display("FAIL fixed_count got %0d acks want 4", acks); end
    @(negedge clk);
    b_stb = '0; b_mack = 1'b0;
  endtask

  task automatic test_abort();
    exp_t e;
    int acks = 0, cyc = 0;
    do_reset();
    @(negedge clk);
    a_adr = {32'h700, 32'h600, 32'h500};
    sb_q.push_back('{m: 0, rdt: 32'h500 ^ K, dat: 32'h0, sel: 4'h0, we: 1'b0});
    a_stb = 3'b001;
    while (acks < 1 && cyc < 10) begin
      @(negedge clk); cyc++;
      a_mack = a_mstb; a_mrdt = a_madr ^ K;
      #1;
      if (a_ack !== 3'b000) begin
        e = sb_q.pop_front();
        n_tests++; if (a_ack !== 3'(1 << e.m)) begin n_fail++; $display("FAIL abort_pre_ack got %b want %b", a_ack, 3'(1 << e.m)); end
        acks++;
        a_stb[0] = 1'b0;
      end
    end
    @(negedge clk);
    a_mack = 1'b0; a_stb[1] = 1'b1;
    @(negedge clk); #1;
    n_tests++; if (a_mstb !== 1'b1 || a_grant !== 2'd1) begin
      n_fail++; $display("FAIL abort_grant got stb=%b grant=%0d want 1/1", a_mstb, a_grant);
    end
    @(negedge clk);
    a_stb[1] = 1'b0;
    #1;
    n_tests++; if (a_mstb !== 1'b0 || a_ack !== 3'b000) begin
      n_fail++; $display("FAIL abort_drop got stb=%b ack=%b want 0/000", a_mstb, a_ack);
    end
    @(negedge clk);
    a_mack = 1'b1; a_stb = 3'b110;
    #1;
    n_tests++; if (a_mstb !== 1'b0 || a_ack !== 3'b000) begin
      n_fail++; $display("FAIL abort_idle_ack_ignored got stb=%b ack=%b want 0/000", a_mstb, a_ack);
    end
    sb_q.push_back('{m: 1, rdt: 32'h600 ^ K, dat: 32'h0, sel: 4'h0, we: 1'b0});
    acks = 0; cyc = 0;
    while (acks < 1 && cyc < 10) begin
      @(negedge clk); cyc++;
      a_mack = a_mstb; a_mrdt = a_madr ^ K;
      #1;
      if (a_ack !== 3'b000) begin
        e = sb_q.pop_front();
        n_tests++; if (a_ack !== 3'(1 << e.m) || a_rdt !== e.rdt) begin
          n_fail++; $display("FAIL abort_reeligible got ack=%b rdt=%h want %b %h", a_ack, a_rdt, 3'(1 << e.m), e.rdt);
        end
        acks++;
      end
    end
    n_tests++; if (acks != 1) begin n_fail++; $display("FAIL abort_post_count got %0d want 1", acks); end
    @(negedge clk);
    a_stb = '0; a_mack = 1'b0;
  endtask

  task automatic test_reset_busy();
    exp_t e;
    int acks = 0, cyc = 0;
    do_reset();
    @(negedge clk);
    a_adr = {32'h2000, 32'h1800, 32'h1400};
    a_stb = 3'b100;
    @(negedge clk); #1;
    n_tests++; if (a_mstb !== 1'b1 || a_grant !== 2'd2) begin
      n_fail++; $display("FAIL rstbusy_pre got stb=%b grant=%0d want 1/2", a_mstb, a_grant);
    end
    a_mack = 1'b1; a_mrdt = a_madr ^ K;
    rst_n  = 1'b0;
    #1;
    n_tests++; if (a_mstb !== 1'b0 || a_ack !== 3'b000 || a_grant !== 2'd0) begin
      n_fail++; $display("FAIL rstbusy_async got stb=%b ack=%b grant=%0d want 0/000/0", a_mstb, a_ack, a_grant);
    end
    @(negedge clk);
    rst_n = 1'b1; a_mack = 1'b0; a_stb = 3'b111;
    sb_q.push_back('{m: 0, rdt: 32'h1400 ^ K, dat: 32'h0, sel: 4'h0, we: 1'b0});
    while (acks < 1 && cyc < 10) begin
      @(negedge clk); cyc++;
      a_mack = a_mstb; a_mrdt = a_madr ^ K;
      #1;
      if (a_ack !== 3'b000) begin
        e = sb_q.pop_front();
        n_tests++; if (a_ack !== 3'(1 << e.m) || a_rdt !== e.rdt) begin
          n_fail++; $display("FAIL rstbusy_first got ack=%b rdt=%h want %b %h", a_ack, a_rdt, 3'(1 << e.m), e.rdt);
        end
        acks++;
      end
    end
    n_tests++; if (acks != 1) begin n_fail++; $display("FAIL rstbusy_count got %0d want 1", acks); end
    @(negedge clk);
    a_stb = '0; a_mack = 1'b0;
  endtask

`ifdef SERVILE_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int busy = 0, cyc = 0;
    logic got = 1'b0;
    do_reset();
    @(negedge clk);
    a_adr[31:0] = 32'h40; a_stb = 3'b001;
    while (!got && cyc < 30) begin
      @(negedge clk); cyc++;
      #1;
      if (a_ack !== 3'b000) begin
        got = 1'b1;
        n_tests++; if (a_ack !== 3'b001 || a_rdt !== 32'hDEAD_BEEF || a_mstb !== 1'b0) begin
          n_fail++; $display("FAIL timeout_ack got ack=%b rdt=%h stb=%b want 001 deadbeef 0", a_ack, a_rdt, a_mstb);
        end
        n_tests++; if (busy != 8) begin n_fail++; $display("FAIL timeout_busy_cycles got %0d want 8", busy); end
        a_stb = '0;
      end else if (a_mstb === 1'b1) begin
        busy++;
      end
    end
    n_tests++; if (!got) begin n_fail++; $display("FAIL timeout_never got no ack want ack"); end
    repeat (3) @(negedge clk);
    #1;
    n_tests++; if (a_tmo !== 1'b1 || a_mstb !== 1'b0) begin
      n_fail++; $display("FAIL timeout_sticky got tmo=%b stb=%b want 1/0", a_tmo, a_mstb);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_time_limit got no finish want finish");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_fixed();
    test_abort();
    test_reset_busy();
`ifdef SERVILE_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
